// File: rtl/stream_golden_checker.sv
// stream_golden_checker
//
// Compares an incoming element stream beat by beat against a golden vector
// stored in an external synchronous-read ROM, and reports a sticky verdict.
//
// Ports:
//   clk          - single rising-edge clock
//   rst          - asynchronous active-high reset
//   in_valid     - upstream element valid
//   in_ready     - checker accepts an element (state-only, no path from in_valid)
//   in_data      - element under test
//   in_last      - marks the final element of the stream
//   golden_addr  - ROM read address (combinational, one beat of lookahead)
//   golden_data  - ROM data: registered read of the previous cycle's golden_addr
//   result       - bit0 pass, bit1 element mismatch, bit2 length mismatch
//   error_index  - index of the offending beat, valid when result[2:1] != 0
module stream_golden_checker #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned GOLDEN_LENGTH = 1024,
    parameter int unsigned ADDR_WIDTH    = (GOLDEN_LENGTH > 1) ? $clog2(GOLDEN_LENGTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] golden_addr,
    input  logic [WIDTH-1:0]      golden_data,
    output logic [2:0]            result,
    output logic [ADDR_WIDTH:0]   error_index
);

    typedef enum logic [2:0] {
        StPrime,
        StCompare,
        StPass,
        StFailElem,
        StFailLen
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(GOLDEN_LENGTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [2:0]            result_q, result_d;
    logic [ADDR_WIDTH:0]   error_index_q, error_index_d;
    logic                  is_last_idx;

    assign is_last_idx = (idx_q == LastIdx);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        result_d      = result_q;
        error_index_d = error_index_q;
        in_ready      = 1'b0;
        golden_addr   = idx_q;

        case (state_q)
            // ROM word 0 is being fetched this cycle.
            StPrime: state_d = StCompare;

            StCompare: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data != golden_data) begin
                        state_d       = StFailElem;
                        result_d      = 3'b010;
                        error_index_d = {1'b0, idx_q};
                    end else if (in_last && !is_last_idx) begin
                        state_d       = StFailLen;
                        result_d      = 3'b100;
                        error_index_d = {1'b0, idx_q};
                    end else if (is_last_idx && !in_last) begin
                        state_d       = StFailLen;
                        result_d      = 3'b100;
                        error_index_d = {1'b0, idx_q};
                    end else if (is_last_idx) begin
                        state_d  = StPass;
                        result_d = 3'b001;
                    end else begin
                        // Fetch the next word now so it is ready for the next beat.
                        idx_d       = idx_q + ADDR_WIDTH'(1);
                        golden_addr = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end

            // Terminal states hold until reset; later input is ignored.
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StPrime;
            idx_q         <= '0;
            result_q      <= '0;
            error_index_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            result_q      <= result_d;
            error_index_q <= error_index_d;
        end
    end

    assign result      = result_q;
    assign error_index = error_index_q;

endmodule

// File: tb/tb_stream_golden_checker.sv
// tb_stream_golden_checker
//
// Bench for stream_golden_checker with an 8-entry golden ROM. A beat-level
// reference model tracks the expected verdict; one compare process checks the
// DUT against it every cycle, and directed scenarios add literal checks.
module tb_stream_golden_checker;

    localparam int WIDTH = 32;
    localparam int GLEN  = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [AW-1:0]    golden_addr;
    logic [WIDTH-1:0] golden_data;
    logic [2:0]       result;
    logic [AW:0]      error_index;

    stream_golden_checker #(
        .WIDTH(WIDTH),
        .GOLDEN_LENGTH(GLEN),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .golden_addr(golden_addr),
        .golden_data(golden_data),
        .result(result),
        .error_index(error_index)
    );

    always #5 clk = ~clk;

    // Golden ROM: single-cycle registered read, no enable.
    logic [WIDTH-1:0] rom [GLEN];
    logic [AW-1:0]    rom_addr_q;
    initial for (int i = 0; i < GLEN; i++) rom[i] = 32'h3F80_0000 + i;
    always @(posedge clk) begin
        golden_data <= rom[golden_addr];
        rom_addr_q  <= golden_addr;
    end

    int compared   = 0;
    int mismatched = 0;
    int trace[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which beat is expected next and what the verdict is.
    bit       m_primed = 1'b0;
    int       m_idx    = 0;
    logic [2:0] m_res  = 3'b000;
    int       m_err    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_primed <= 1'b0;
            m_idx    <= 0;
            m_res    <= 3'b000;
            m_err    <= 0;
        end else if (!m_primed) begin
            m_primed <= 1'b1;
        end else if (m_res == 3'b000 && in_valid) begin
            if (in_data != rom[m_idx]) begin
                m_res <= 3'b010;
                m_err <= m_idx;
            end else if (in_last && m_idx < GLEN - 1) begin
                m_res <= 3'b100;
                m_err <= m_idx;
            end else if (m_idx == GLEN - 1) begin
                m_res <= in_last ? 3'b001 : 3'b100;
                m_err <= in_last ? 0 : m_idx;
            end else begin
                m_idx <= m_idx + 1;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin : cmp
        bit exp_ready;
        int exp_addr;
        exp_ready = m_primed && (m_res == 3'b000);
        exp_addr  = (exp_ready && in_valid && in_data == rom[m_idx] && !in_last
                     && m_idx < GLEN - 1) ? m_idx + 1 : m_idx;
        chk("in_ready", in_ready, exp_ready);
        chk("result", result, m_res);
        chk("error_index", error_index, m_err);
        chk("golden_addr", golden_addr, exp_addr);
        if (in_valid && in_ready) trace.push_back(int'(rom_addr_q));
    end

    // Reset and step past the priming cycle so in_ready is already high.
    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive beats 0..nbeats-1 until done or a verdict appears.
    task automatic run_stream(input int nbeats, input int bad, input int lastb,
                              input bit gaps, input int max_cycles, output int cycles);
        int k = 0;
        bit hs;
        cycles = 0;
        while (k < nbeats && result == 3'b000 && cycles < max_cycles) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = (k == bad) ? 32'hDEAD_BEEF : 32'h3F80_0000 + k;
            in_last  = (k == lastb);
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
            cycles++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (cycles >= max_cycles) begin
            compared++;
            mismatched++;
            $display("FAIL stream_timeout: got %0d beats, expected %0d", k, nbeats);
        end
    endtask

    int cyc;

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // Priming cycle: not ready yet.
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_result", result, 3'b000);
        chk("reset_error_index", error_index, 0);
        @(posedge clk);
        #1;
        chk("ready_after_prime", in_ready, 1'b1);

        // Matching stream, full throughput.
        run_stream(8, -1, 7, 1'b0, 50, cyc);
        chk("match_result", result, 3'b001);
        chk("match_cycles", cyc, 8);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("match_sticky", result, 3'b001);

        // Element error on beat 5.
        reset_dut();
        run_stream(8, 5, 7, 1'b0, 50, cyc);
        chk("elem_result", result, 3'b010);
        chk("elem_index", error_index, 5);
        chk("elem_ready", in_ready, 1'b0);

        // Short stream: in_last on beat 3.
        reset_dut();
        run_stream(8, -1, 3, 1'b0, 50, cyc);
        chk("short_result", result, 3'b100);
        chk("short_index", error_index, 3);

        // Long stream: beat 7 without in_last; beat 8 must not be taken.
        reset_dut();
        run_stream(9, -1, 8, 1'b0, 50, cyc);
        chk("long_result", result, 3'b100);
        chk("long_index", error_index, 7);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0008;
        in_last  = 1'b1;
        @(negedge clk);
        chk("long_beat8_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("long_result_hold", result, 3'b100);
        chk("long_index_hold", error_index, 7);

        // Random gaps: every ROM word read exactly once, in order.
        reset_dut();
        trace.delete();
        run_stream(8, -1, 7, 1'b1, 400, cyc);
        chk("gaps_result", result, 3'b001);
        chk("gaps_trace_len", trace.size(), 8);
        for (int i = 0; i < trace.size() && i < 8; i++) chk("gaps_trace", trace[i], i);

        // Reset after beat 4, then replay the whole stream.
        reset_dut();
        run_stream(5, -1, 7, 1'b0, 50, cyc);
        chk("mid_before_reset", result, 3'b000);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_during_reset", result, 3'b000);
        chk("mid_ready_reset", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_after_reset", result, 3'b000);
        @(posedge clk);
        #1;
        run_stream(8, -1, 7, 1'b0, 50, cyc);
        chk("mid_final_result", result, 3'b001);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
